// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared widths and FSM state type for the motion-estimation search control
package me_pkg;
    localparam int SAD32_W = 18;
    localparam int MVX_W   = 5;
    localparam int MVY_W   = 7;
    localparam int REF_W   = 256;
    localparam int CUR_W   = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CUR,
        ST_SEARCH,
        ST_DRAIN,
        ST_DONE
    } me_state_t;
endpackage

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - candidate delay line and running minimum of SAD32x32 with its motion vector
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push_valid,
    input  logic [MVX_W-1:0]   push_mvx,
    input  logic [MVY_W-1:0]   push_mvy,
    input  logic [SAD32_W-1:0] sad32x32,
    output logic               pending,
    output logic [SAD32_W-1:0] best_sad,
    output logic [MVX_W-1:0]   best_mv_x,
    output logic [MVY_W-1:0]   best_mv_y
);
    logic [DEPTH-1:0] vld;
    logic [MVX_W-1:0] mvx_q [DEPTH];
    logic [MVY_W-1:0] mvy_q [DEPTH];
    logic             first;

    // Only stages ahead of the tap count: the tap itself is consumed on this edge.
    assign pending = push_valid | (|vld[DEPTH-2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            first     <= 1'b1;
            best_sad  <= '1;
            best_mv_x <= '0;
            best_mv_y <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mvx_q[i] <= '0;
                mvy_q[i] <= '0;
            end
        end else begin
            vld      <= {vld[DEPTH-2:0], push_valid};
            mvx_q[0] <= push_mvx;
            mvy_q[0] <= push_mvy;
            for (int i = 1; i < DEPTH; i++) begin
                mvx_q[i] <= mvx_q[i-1];
                mvy_q[i] <= mvy_q[i-1];
            end
            // Strict less-than keeps the earliest candidate on ties.
            if (clear) begin
                first <= 1'b1;
            end else if (vld[DEPTH-1] && (first || sad32x32 < best_sad)) begin
                first     <= 1'b0;
                best_sad  <= sad32x32;
                best_mv_x <= mvx_q[DEPTH-1];
                best_mv_y <= mvy_q[DEPTH-1];
            end
        end
    end
endmodule

// File: rtl/basic_layer_search_ctrl.sv
// rtl/basic_layer_search_ctrl.sv - sequencer for the Basic_layer_search SAD datapath
module basic_layer_search_ctrl
    import me_pkg::*;
#(
    parameter int CUR_BEATS   = 16,
    parameter int REF_PRELOAD = 32,
    parameter int SEARCH_ROWS = 64,
    parameter int SEARCH_COLS = 32,
    parameter int SAD_LAT     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               cur_rd_en,
    output logic [3:0]         cur_rd_addr,
    input  logic [CUR_W-1:0]   cur_rd_data,
    output logic               ref_rd_en,
    output logic [11:0]        ref_rd_addr,
    input  logic [REF_W-1:0]   ref_rd_data,
    output logic [CUR_W-1:0]   current_64pixels,
    output logic [REF_W-1:0]   ref_input,
    output logic               ref_begin_prepare,
    output logic               pe_begin_prepare,
    input  logic [SAD32_W-1:0] sad32x32,
    output logic [SAD32_W-1:0] best_sad,
    output logic [MVX_W-1:0]   best_mv_x,
    output logic [MVY_W-1:0]   best_mv_y
);
    localparam logic [3:0]       LAST_BEAT = 4'(CUR_BEATS - 1);
    localparam logic [6:0]       LAST_ROW  = 7'(REF_PRELOAD + SEARCH_ROWS - 1);
    localparam logic [6:0]       PRELOAD   = 7'(REF_PRELOAD);
    localparam logic [MVX_W-1:0] LAST_COL  = MVX_W'(SEARCH_COLS - 1);

    me_state_t        state, state_d;
    logic [3:0]       beat;
    logic [6:0]       row;
    logic [MVX_W-1:0] col;
    logic             cand, pending;
    logic             cur_vld, ref_vld, pe_vld;

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign cur_rd_en   = (state == ST_LOAD_CUR);
    assign cur_rd_addr = beat;
    assign ref_rd_en   = (state == ST_SEARCH);
    assign ref_rd_addr = {col, row};
    assign cand        = ref_rd_en && (row >= PRELOAD);

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:     if (start) state_d = ST_LOAD_CUR;
            ST_LOAD_CUR: if (beat == LAST_BEAT) state_d = ST_SEARCH;
            ST_SEARCH:   if (row == LAST_ROW && col == LAST_COL) state_d = ST_DRAIN;
            ST_DRAIN:    if (!pending) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            beat  <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_d;
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    row  <= '0;
                    col  <= '0;
                end
                ST_LOAD_CUR: beat <= beat + 4'd1;
                ST_SEARCH: begin
                    if (row == LAST_ROW) begin
                        row <= '0;
                        col <= col + MVX_W'(1);
                    end else begin
                        row <= row + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM data lands one cycle after the read; register it and the strobes one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_vld           <= 1'b0;
            ref_vld           <= 1'b0;
            pe_vld            <= 1'b0;
            current_64pixels  <= '0;
            ref_input         <= '0;
            ref_begin_prepare <= 1'b0;
            pe_begin_prepare  <= 1'b0;
        end else begin
            cur_vld           <= cur_rd_en;
            ref_vld           <= ref_rd_en;
            pe_vld            <= cand;
            ref_begin_prepare <= ref_vld;
            pe_begin_prepare  <= pe_vld;
            if (cur_vld) current_64pixels <= cur_rd_data;
            if (ref_vld) ref_input <= ref_rd_data;
        end
    end

    sad_min_tracker #(
        .DEPTH (2 + SAD_LAT)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == ST_IDLE && start),
        .push_valid (cand),
        .push_mvx   (col),
        .push_mvy   (row - PRELOAD),
        .sad32x32   (sad32x32),
        .pending    (pending),
        .best_sad   (best_sad),
        .best_mv_x  (best_mv_x),
        .best_mv_y  (best_mv_y)
    );
endmodule

// File: tb/tb_basic_layer_search_ctrl.sv
// tb/tb_basic_layer_search_ctrl.sv - scoreboard bench for basic_layer_search_ctrl with a behavioural SAD model
module tb_basic_layer_search_ctrl;
    localparam int NCOL = 32;
    localparam int NROW = 64;
    localparam int PRE  = 32;
    localparam int LAT  = 4;
    localparam longint DONE_OFS = 16 + NCOL * (PRE + NROW) + 3 + LAT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, cur_rd_en, ref_rd_en, ref_begin_prepare, pe_begin_prepare;
    logic [3:0]   cur_rd_addr;
    logic [11:0]  ref_rd_addr;
    logic [511:0] cur_rd_data = '0;
    logic [255:0] ref_rd_data = '0;
    logic [511:0] current_64pixels;
    logic [255:0] ref_input;
    logic [17:0]  sad32x32 = '0;
    logic [17:0]  best_sad;
    logic [4:0]   best_mv_x;
    logic [6:0]   best_mv_y;

    basic_layer_search_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data),
        .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
        .current_64pixels(current_64pixels), .ref_input(ref_input),
        .ref_begin_prepare(ref_begin_prepare), .pe_begin_prepare(pe_begin_prepare),
        .sad32x32(sad32x32), .best_sad(best_sad), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sad;
        longint mvx;
        longint mvy;
        longint done_cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    int     sad_tab[NCOL][NROW];
    int     sad_at[64];
    bit     has_at[64];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [511:0] cur_word(input int a);
        return {16{32'hC0DE0000 + 32'(a)}};
    endfunction

    // SRAM models (one cycle read latency) and the SAD datapath model.
    bit          cur_pend = 0, ref_pend = 0;
    logic [3:0]  cur_pa;
    logic [11:0] ref_pa;
    always @(negedge clk) begin
        logic [255:0] rw;
        int           c, r, idx;
        cur_rd_data = cur_pend ? cur_word(int'(cur_pa)) : {16{$urandom}};
        rw          = {8{$urandom}};
        if (ref_pend) rw[11:0] = ref_pa;
        ref_rd_data = rw;
        cur_pend = cur_rd_en; cur_pa = cur_rd_addr;
        ref_pend = ref_rd_en; ref_pa = ref_rd_addr;
        if (pe_begin_prepare && rst_n) begin
            c = int'(ref_input[11:7]);
            r = int'(ref_input[6:0]) - PRE;
            idx = int'((cyc + LAT) % 64);
            has_at[idx] = 1;
            sad_at[idx] = (r >= 0 && r < NROW) ? sad_tab[c][r] : 0;
        end
        idx = int'(cyc % 64);
        if (has_at[idx]) begin
            sad32x32 = 18'(sad_at[idx]);
            has_at[idx] = 0;
        end else begin
            sad32x32 = 18'($urandom);
        end
    end

    // Monitor: per-run strobe statistics, busy continuity, and scoreboard pop on done.
    int     cur_cnt, rb_cnt, pe_cnt, busy_gap;
    longint first_ref, first_pe;
    bit     run_on = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || (start && !busy)) begin
            cur_cnt = 0; rb_cnt = 0; pe_cnt = 0; busy_gap = 0;
            first_ref = -1; first_pe = -1;
            run_on = rst_n;
        end else begin
            if (cur_rd_en) cur_cnt++;
            if (ref_begin_prepare) rb_cnt++;
            if (pe_begin_prepare) pe_cnt++;
            if (ref_rd_en && first_ref < 0) first_ref = cyc;
            if (pe_begin_prepare && first_pe < 0) first_pe = cyc;
            if (run_on && !busy) busy_gap++;
            if (done) begin
                run_on = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("best_sad", longint'(best_sad), e.sad);
                    check("best_mv_x", longint'(best_mv_x), e.mvx);
                    check("best_mv_y", longint'(best_mv_y), e.mvy);
                    check("done_cycle", cyc, e.done_cyc);
                    check("cur_rd_en_cycles", cur_cnt, 16);
                    check("ref_begin_prepare_cycles", rb_cnt, NCOL * (PRE + NROW));
                    check("pe_begin_prepare_cycles", pe_cnt, NCOL * NROW);
                    check("first_pe_offset", first_pe - first_ref, 34);
                    check("busy_gaps", busy_gap, 0);
                    check("cur_data_lo", longint'(current_64pixels[63:0]), longint'(cur_word(15) >> 448));
                end
            end
        end
    end

    function automatic exp_t model(input longint start_cyc);
        exp_t e;
        bit   first = 1;
        e.sad = 0; e.mvx = 0; e.mvy = 0;
        for (int c = 0; c < NCOL; c++)
            for (int r = 0; r < NROW; r++)
                if (first || sad_tab[c][r] < e.sad) begin
                    first = 0;
                    e.sad = sad_tab[c][r]; e.mvx = c; e.mvy = r;
                end
        e.done_cyc = start_cyc + DONE_OFS;
        return e;
    endfunction

    task automatic fill(input int mode);
        for (int c = 0; c < NCOL; c++)
            for (int r = 0; r < NROW; r++)
                case (mode)
                    0: sad_tab[c][r] = 1000;
                    1: sad_tab[c][r] = (c == 7 && r == 20) ? 100 : 500;
                    2: sad_tab[c][r] = ((c == 3 && r == 10) || (c == 9 && r == 2)) ? 50 : 500;
                    3: sad_tab[c][r] = int'($urandom_range(3, 40));
                    default: sad_tab[c][r] = int'($urandom_range(18'h3FF00, 18'h3FFFF));
                endcase
    endtask

    // abort_at > 0 pulls reset that many cycles after start; mid_start re-pulses start at cycle 500.
    task automatic run_search(input int mode, input bit mid_start, input int abort_at);
        exp_t   e;
        longint s;
        fill(mode);
        s = cyc;
        e = model(s);
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) begin
            if (mid_start) start = (cyc == s + 500);
            if (abort_at > 0 && cyc == s + abort_at) begin
                rst_n = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check("abort_best_sad", longint'(best_sad), 18'h3FFFF);
                check("abort_best_mv", longint'({best_mv_x, best_mv_y}), 0);
                check("abort_busy", longint'(busy), 0);
                check("abort_done", longint'(done), 0);
                check("abort_ref_rd_en", longint'(ref_rd_en), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (exp_q.size() > 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        if (abort_at == 0) begin
            check("busy_after_done", longint'(busy), 0);
            repeat (3) @(negedge clk);
            check("best_sad_held", longint'(best_sad), e.sad);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_best_sad", longint'(best_sad), 18'h3FFFF);
        check("rst_best_mv", longint'({best_mv_x, best_mv_y}), 0);
        check("rst_rd_en", longint'({cur_rd_en, ref_rd_en}), 0);
        check("rst_strobes", longint'({ref_begin_prepare, pe_begin_prepare}), 0);
        check("rst_ref_input", longint'(ref_input[63:0]), 0);
        check("rst_cur_data", longint'(current_64pixels[63:0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_search(0, 1'b0, 0);
        run_search(1, 1'b1, 0);
        run_search(2, 1'b0, 0);
        run_search(3, 1'b0, 1200);
        repeat (2) @(negedge clk);
        run_search(3, 1'b0, 0);
        run_search(4, 1'b0, 0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/basic_layer_search_ctrl.md
# basic_layer_search_ctrl

Sequencer for the `Basic_layer_search` SAD datapath.
- On `start`, it loads the current block from the current-frame SRAM and streams reference rows column by column from the reference SRAM.
- It drives the datapath's prepare strobes and scans the full search window.
- It tracks the minimum `SAD32x32` and reports the winning motion vector.
- It sits between the ME top-level control and `Basic_layer_search`, replacing the free-running strobes used in unit benches.

## Interface
Parameters:
- `CUR_BEATS`, default 16: beats of 64 pixels forming the current block.
- `REF_PRELOAD`, default 32: reference rows loaded per column before SAD evaluation starts.
- `SEARCH_ROWS`, default 64: candidate rows per search column.
- `SEARCH_COLS`, default 32: search columns; 5-bit column index.
- `SAD_LAT`, default 4: cycles from a row on `ref_input` to its `SAD32x32`.

Ports:
- `clk` in 1: single clock. Reset is asynchronous, active-low (`rst_n`).
- `rst_n` in 1: async active-low reset.
- `start` in 1: begin a search; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse; `best_*` outputs are valid from this cycle.
- `cur_rd_en` out 1 / `cur_rd_addr` out 4: current-block SRAM read; data returns 1 cycle later.
- `cur_rd_data` in 512: current SRAM data.
- `ref_rd_en` out 1 / `ref_rd_addr` out 12: reference SRAM read, `{col[4:0], row[6:0]}`; data returns 1 cycle later.
- `ref_rd_data` in 256: reference SRAM data.
- `current_64pixels` out 512 / `ref_input` out 256: registered SRAM data to the datapath.
- `ref_begin_prepare` out 1 / `pe_begin_prepare` out 1: datapath strobes.
- `sad32x32` in 18: `SAD32x32` from the datapath.
- `best_sad` out 18, `best_mv_x` out 5, `best_mv_y` out 7: search result.

## Operation
- FSM states: IDLE, LOAD_CUR, SEARCH, DRAIN, DONE.
- IDLE:
  - `start`=1 moves to LOAD_CUR.
  - `best_*` hold the last result.
- LOAD_CUR:
  - `cur_rd_en`=1 for `CUR_BEATS` cycles; addr runs 0..`CUR_BEATS`-1.
  - Then move to SEARCH with col=0, row=0.
- SEARCH:
  - `ref_rd_en`=1 every cycle; row runs 0..`REF_PRELOAD+SEARCH_ROWS`-1.
  - When row wraps to 0, col increments.
  - After the last row of col `SEARCH_COLS`-1, move to DRAIN.
- Data path to the datapath:
  - Read data is registered onto `current_64pixels`/`ref_input` in the cycle after it returns.
  - Each output holds when no data returns.
  - Strobes are aligned with the data, i.e. 2 cycles after the matching `rd_en`.
  - `ref_begin_prepare`=1 for every ref row presented.
  - `pe_begin_prepare`=1 only for rows with index ≥ `REF_PRELOAD`; each such row is one candidate with mv = (col, row−`REF_PRELOAD`).
- Candidate tracking:
  - A delay line of `2+SAD_LAT` stages carries {valid, col, mvy}.
  - On a valid tap, `sad32x32` is compared with the current best.
  - The first candidate of a search loads unconditionally.
  - Later candidates replace the best only on strict `<`, so a tie keeps the earlier candidate (column-major, row order).
- DRAIN: waits until the delay line is empty, then moves to DONE.
- DONE: pulses `done` for one cycle, then returns to IDLE.
- `start` while not in IDLE is ignored; it is not queued.

## Timing
- Cycle 0 is `start` sampled high in IDLE.
  - `cur_rd_en` is high in cycles 1..`CUR_BEATS`.
  - The first `ref_rd_en` is in cycle `CUR_BEATS`+1.
- Let C = `CUR_BEATS + SEARCH_COLS*(REF_PRELOAD+SEARCH_ROWS)`, the cycle of the last `ref_rd_en`.
  - The final best update and the `done` pulse occur in cycle C+3+`SAD_LAT`. With defaults this is 3095.
- Reset values:
  - All outputs are 0, except `best_sad`, which resets to 18'h3FFFF.
  - FSM in IDLE; delay line cleared.
- Reset mid-search aborts immediately:
  - no `done`;
  - `best_*` return to their reset values;
  - a new `start` after reset runs a full search.
- The 18-bit compare is unsigned, with no saturation.

## Structure
- Shared package `me_pkg`:
  - FSM state enum;
  - `SAD32_W`=18, `MVX_W`=5, `MVY_W`=7, `REF_W`=256, `CUR_W`=512.
- Sub-module `sad_min_tracker`: the delay line plus compare/update of `best_*`, with a first-candidate flag and clear.
- FSM and address counters stay in the top module.

## Test plan
- All `sad32x32`=1000 constant → `best_sad`=1000, mv=(0,0) (tie rule); `done` in cycle 3095.
- SRAM model returns SAD 100 only for candidate (7,20), 500 elsewhere → `best_sad`=100, mv=(7,20).
- Two equal minima of 50 at (3,10) and (9,2) → mv=(3,10).
- Count strobes → `cur_rd_en` 16 cycles; `ref_begin_prepare` 3072 cycles; `pe_begin_prepare` 2048 cycles, first one 34 cycles after the first `ref_rd_en`.
- `start` pulsed at cycle 500 mid-search → ignored; single `done` at 3095; `busy` continuous.
- `rst_n` low at cycle 1200 → outputs reset (`best_sad`=3FFFF), no `done`; restart completes normally.
